elink_tx_arbiter: RTL and testbench

- Frame-level round-robin arbiter and sequencer for the 10-bit elink transmit path.
- Three sources (for example the CAN-bus bridge channels) each offer 10-bit encoded words with a valid/ready/last handshake.
- The block grants one source for a whole frame, drives the one-hot buffer enables and the registered output word, and inserts comma idle words between frames and whenever there is no data.
- It sits between the per-channel transmit formatters and the elink serializer.

---
 rtl/elink_pkg.sv | 23 ++
 rtl/rr_pick3.sv | 32 +++
 rtl/elink_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_elink_tx_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/elink_pkg.sv
// Shared types and constants for the elink transmit arbiter.
// The idle word is a K28.5 comma with the two control bits set.
package elink_pkg;

    localparam int ELINK_WORD_W = 10;
    localparam logic [7:0] COMMA_K28_5 = 8'hBC;
    localparam logic [ELINK_WORD_W-1:0] ELINK_RESET_WORD = 10'h3BC;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP
    } tx_state_e;

    function automatic logic [1:0] onehot3_to_idx(input logic [2:0] oh);
        case (oh)
            3'b010:  return 2'd1;
            3'b100:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin picker: scans from ptr+1 (mod 3) and
// returns the first requester as a one-hot grant.
module rr_pick3 (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] grant,
    output logic       found
);

    always_comb begin
        grant = 3'b000;
        found = |req;
        case (ptr)
            2'd0: begin
                if (req[1])      grant = 3'b010;
                else if (req[2]) grant = 3'b100;
                else if (req[0]) grant = 3'b001;
            end
            2'd1: begin
                if (req[2])      grant = 3'b100;
                else if (req[0]) grant = 3'b001;
                else if (req[1]) grant = 3'b010;
            end
            default: begin
                if (req[0])      grant = 3'b001;
                else if (req[1]) grant = 3'b010;
                else if (req[2]) grant = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/elink_tx_arbiter.sv
// Frame-level round-robin arbiter for three 10-bit elink sources; holds a
// grant for a whole frame and pads with comma words between frames.
module elink_tx_arbiter
    import elink_pkg::*;
#(
    parameter int GAP_WORDS       = 1,
    parameter int MAX_FRAME_WORDS = 64,
    parameter int CNT_W           = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        word_ce,
    input  logic [7:0]  kchar_comma,
    input  logic [2:0]  tx_valid,
    input  logic [2:0]  tx_last,
    input  logic [9:0]  tx_data0,
    input  logic [9:0]  tx_data1,
    input  logic [9:0]  tx_data2,
    output logic [2:0]  tx_ready,
    output logic        buffer_en0,
    output logic        buffer_en1,
    output logic        buffer_en2,
    output logic [9:0]  data_tra_out,
    output logic        frame_abort,
    output logic        busy
);

    localparam int GAP_W = 4;

    tx_state_e         state_q, state_d;
    logic [2:0]        grant_q, grant_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]  word_cnt_q, word_cnt_d, word_cnt_inc;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d, gap_cnt_inc;
    logic [9:0]        data_q, data_d;
    logic              abort_q, abort_d;

    logic [2:0]        pick_grant;
    logic              pick_found;
    logic [2:0]        sel_oh;
    logic              sel_valid, sel_last;
    logic [9:0]        sel_word, comma_word;
    logic [2:0]        ready_d;

    rr_pick3 u_pick (
        .req   (tx_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .found (pick_found)
    );

    // In IDLE the candidate is the fresh pick; otherwise it is the held grant.
    assign sel_oh       = (state_q == ST_IDLE) ? pick_grant : grant_q;
    assign sel_valid    = |(tx_valid & sel_oh);
    assign sel_last     = |(tx_last & sel_oh);
    assign sel_word     = ({10{sel_oh[0]}} & tx_data0)
                        | ({10{sel_oh[1]}} & tx_data1)
                        | ({10{sel_oh[2]}} & tx_data2);
    assign comma_word   = {2'b11, kchar_comma};
    assign word_cnt_inc = word_cnt_q + CNT_W'(1);
    assign gap_cnt_inc  = gap_cnt_q + GAP_W'(1);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        word_cnt_d = word_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        data_d     = data_q;
        abort_d    = 1'b0;
        ready_d    = 3'b000;

        if (word_ce) begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        ready_d    = pick_grant;
                        grant_d    = pick_grant;
                        ptr_d      = onehot3_to_idx(pick_grant);
                        word_cnt_d = CNT_W'(1);
                        gap_cnt_d  = '0;
                        data_d     = sel_word;
                        state_d    = sel_last ? ST_GAP : ST_SEND;
                    end else begin
                        grant_d = 3'b000;
                        data_d  = comma_word;
                    end
                end
                ST_SEND: begin
                    ready_d = grant_q;
                    if (sel_valid) begin
                        data_d     = sel_word;
                        word_cnt_d = word_cnt_inc;
                        gap_cnt_d  = '0;
                        if (sel_last) begin
                            state_d = ST_GAP;
                        end else if (word_cnt_inc == CNT_W'(MAX_FRAME_WORDS)) begin
                            abort_d = 1'b1;
                            state_d = ST_GAP;
                        end
                    end else begin
                        // Underrun: pad with comma, keep grant and count.
                        data_d = comma_word;
                    end
                end
                ST_GAP: begin
                    grant_d   = 3'b000;
                    data_d    = comma_word;
                    gap_cnt_d = gap_cnt_inc;
                    if (gap_cnt_inc == GAP_W'(GAP_WORDS)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= 3'b000;
            ptr_q      <= 2'd2;
            word_cnt_q <= '0;
            gap_cnt_q  <= '0;
            data_q     <= ELINK_RESET_WORD;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            word_cnt_q <= word_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            data_q     <= data_d;
            abort_q    <= abort_d;
        end
    end

    assign tx_ready     = ready_d;
    assign buffer_en0   = grant_q[0];
    assign buffer_en1   = grant_q[1];
    assign buffer_en2   = grant_q[2];
    assign data_tra_out = data_q;
    assign frame_abort  = abort_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_elink_tx_arbiter.sv
// Directed vector bench for elink_tx_arbiter (GAP_WORDS=1, MAX_FRAME_WORDS=4).
module tb_elink_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        word_ce;
    logic [7:0]  kchar_comma;
    logic [2:0]  tx_valid, tx_last, tx_ready;
    logic [9:0]  tx_data0, tx_data1, tx_data2, data_tra_out;
    logic        buffer_en0, buffer_en1, buffer_en2, frame_abort, busy;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int row       = 0;

    localparam logic [7:0] K = 8'hBC;

    elink_tx_arbiter #(
        .GAP_WORDS       (1),
        .MAX_FRAME_WORDS (4),
        .CNT_W           (10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .word_ce      (word_ce),
        .kchar_comma  (kchar_comma),
        .tx_valid     (tx_valid),
        .tx_last      (tx_last),
        .tx_data0     (tx_data0),
        .tx_data1     (tx_data1),
        .tx_data2     (tx_data2),
        .tx_ready     (tx_ready),
        .buffer_en0   (buffer_en0),
        .buffer_en1   (buffer_en1),
        .buffer_en2   (buffer_en2),
        .data_tra_out (data_tra_out),
        .frame_abort  (frame_abort),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       ce;
        logic [7:0] kchar;
        logic [2:0] valid;
        logic [2:0] last;
        logic [9:0] d0;
        logic [9:0] d1;
        logic [9:0] d2;
        logic [2:0] exp_ready;
        logic [9:0] exp_data;
        logic [2:0] exp_en;
        logic       exp_abort;
        logic       exp_busy;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic c, input logic [7:0] k,
                                input logic [2:0] v, input logic [2:0] l,
                                input logic [9:0] a, input logic [9:0] b, input logic [9:0] d,
                                input logic [2:0] er, input logic [9:0] ed,
                                input logic [2:0] ee, input logic ea, input logic eb);
        vec_t x;
        x.rst = r; x.ce = c; x.kchar = k; x.valid = v; x.last = l;
        x.d0 = a; x.d1 = b; x.d2 = d;
        x.exp_ready = er; x.exp_data = ed; x.exp_en = ee;
        x.exp_abort = ea; x.exp_busy = eb;
        return x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp)
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        else
            pass_cnt++;
    endtask

    // Drive one clk of inputs, check tx_ready before the edge and registered outputs after it.
    task automatic apply(input vec_t v);
        rst = v.rst; word_ce = v.ce; kchar_comma = v.kchar;
        tx_valid = v.valid; tx_last = v.last;
        tx_data0 = v.d0; tx_data1 = v.d1; tx_data2 = v.d2;
        #1;
        check("tx_ready", 32'(tx_ready), 32'(v.exp_ready));
        @(posedge clk);
        #1;
        check("data_tra_out", 32'(data_tra_out), 32'(v.exp_data));
        check("buffer_en", 32'({buffer_en2, buffer_en1, buffer_en0}), 32'(v.exp_en));
        check("frame_abort", 32'(frame_abort), 32'(v.exp_abort));
        check("busy", 32'(busy), 32'(v.exp_busy));
        row++;
    endtask

    vec_t tab1[$];
    vec_t tab2[$];

    initial begin
        // Idle, comma sampling, ce hold, single source, reset, fairness.
        tab1.push_back(mk(0,1,K,    3'b000,3'b000,10'h000,10'h000,10'h000, 3'b000,10'h3BC,3'b000,0,0));
        tab1.push_back(mk(0,1,8'h7C,3'b000,3'b000,10'h000,10'h000,10'h000, 3'b000,10'h37C,3'b000,0,0));
        tab1.push_back(mk(0,0,K,    3'b000,3'b000,10'h000,10'h000,10'h000, 3'b000,10'h37C,3'b000,0,0));
        tab1.push_back(mk(0,1,K,    3'b000,3'b000,10'h000,10'h000,10'h000, 3'b000,10'h3BC,3'b000,0,0));
        tab1.push_back(mk(0,1,K,3'b010,3'b000,10'h000,10'h101,10'h000, 3'b010,10'h101,3'b010,0,1));
        tab1.push_back(mk(0,1,K,3'b010,3'b000,10'h000,10'h102,10'h000, 3'b010,10'h102,3'b010,0,1));
        tab1.push_back(mk(0,1,K,3'b010,3'b010,10'h000,10'h103,10'h000, 3'b010,10'h103,3'b010,0,1));
        tab1.push_back(mk(0,1,K,3'b111,3'b000,10'h3FF,10'h3FF,10'h3FF, 3'b000,10'h3BC,3'b000,0,0));
        tab1.push_back(mk(1,1,K,3'b000,3'b000,10'h000,10'h000,10'h000, 3'b000,10'h3BC,3'b000,0,0));
        tab1.push_back(mk(0,1,K,3'b111,3'b000,10'h0A1,10'h0B1,10'h0C1, 3'b001,10'h0A1,3'b001,0,1));
        tab1.push_back(mk(0,1,K,3'b111,3'b001,10'h0A2,10'h0B1,10'h0C1, 3'b001,10'h0A2,3'b001,0,1));
        tab1.push_back(mk(0,1,K,3'b111,3'b000,10'h1A1,10'h0B1,10'h0C1, 3'b000,10'h3BC,3'b000,0,0));
        tab1.push_back(mk(0,1,K,3'b111,3'b000,10'h1A1,10'h0B1,10'h0C1, 3'b010,10'h0B1,3'b010,0,1));
        tab1.push_back(mk(0,1,K,3'b111,3'b010,10'h1A1,10'h0B2,10'h0C1, 3'b010,10'h0B2,3'b010,0,1));
        tab1.push_back(mk(0,1,K,3'b111,3'b000,10'h1A1,10'h1B1,10'h0C1, 3'b000,10'h3BC,3'b000,0,0));
        tab1.push_back(mk(0,1,K,3'b111,3'b000,10'h1A1,10'h1B1,10'h0C1, 3'b100,10'h0C1,3'b100,0,1));
        tab1.push_back(mk(0,1,K,3'b111,3'b100,10'h1A1,10'h1B1,10'h0C2, 3'b100,10'h0C2,3'b100,0,1));
        tab1.push_back(mk(0,1,K,3'b111,3'b000,10'h1A1,10'h1B1,10'h1C1, 3'b000,10'h3BC,3'b000,0,0));
        tab1.push_back(mk(0,1,K,3'b111,3'b000,10'h1A1,10'h1B1,10'h1C1, 3'b001,10'h1A1,3'b001,0,1));
        tab1.push_back(mk(0,1,K,3'b111,3'b001,10'h1A2,10'h1B1,10'h1C1, 3'b001,10'h1A2,3'b001,0,1));
        tab1.push_back(mk(0,1,K,3'b111,3'b000,10'h2A1,10'h1B1,10'h1C1, 3'b000,10'h3BC,3'b000,0,0));
        tab1.push_back(mk(0,1,K,3'b111,3'b000,10'h2A1,10'h1B1,10'h1C1, 3'b010,10'h1B1,3'b010,0,1));
        tab1.push_back(mk(0,1,K,3'b111,3'b010,10'h2A1,10'h1B2,10'h1C1, 3'b010,10'h1B2,3'b010,0,1));
        tab1.push_back(mk(0,1,K,3'b111,3'b000,10'h2A1,10'h2B1,10'h1C1, 3'b000,10'h3BC,3'b000,0,0));
        tab1.push_back(mk(0,1,K,3'b111,3'b000,10'h2A1,10'h2B1,10'h1C1, 3'b100,10'h1C1,3'b100,0,1));
        tab1.push_back(mk(0,1,K,3'b111,3'b100,10'h2A1,10'h2B1,10'h1C2, 3'b100,10'h1C2,3'b100,0,1));
        tab1.push_back(mk(0,1,K,3'b000,3'b000,10'h000,10'h000,10'h000, 3'b000,10'h3BC,3'b000,0,0));

        // Abort at 4 words, re-grant of the remainder, last exactly at the budget, reset mid-frame.
        tab2.push_back(mk(0,1,K,3'b100,3'b000,10'h000,10'h000,10'h301, 3'b100,10'h301,3'b100,0,1));
        tab2.push_back(mk(0,1,K,3'b100,3'b000,10'h000,10'h000,10'h302, 3'b100,10'h302,3'b100,0,1));
        tab2.push_back(mk(0,1,K,3'b100,3'b000,10'h000,10'h000,10'h303, 3'b100,10'h303,3'b100,0,1));
        tab2.push_back(mk(0,1,K,3'b100,3'b000,10'h000,10'h000,10'h304, 3'b100,10'h304,3'b100,1,1));
        tab2.push_back(mk(0,1,K,3'b100,3'b000,10'h000,10'h000,10'h305, 3'b000,10'h3BC,3'b000,0,0));
        tab2.push_back(mk(0,1,K,3'b100,3'b000,10'h000,10'h000,10'h305, 3'b100,10'h305,3'b100,0,1));
        tab2.push_back(mk(0,1,K,3'b100,3'b100,10'h000,10'h000,10'h306, 3'b100,10'h306,3'b100,0,1));
        tab2.push_back(mk(0,1,K,3'b000,3'b000,10'h000,10'h000,10'h000, 3'b000,10'h3BC,3'b000,0,0));
        tab2.push_back(mk(0,1,K,3'b010,3'b000,10'h000,10'h111,10'h000, 3'b010,10'h111,3'b010,0,1));
        tab2.push_back(mk(0,1,K,3'b010,3'b000,10'h000,10'h112,10'h000, 3'b010,10'h112,3'b010,0,1));
        tab2.push_back(mk(0,1,K,3'b010,3'b000,10'h000,10'h113,10'h000, 3'b010,10'h113,3'b010,0,1));
        tab2.push_back(mk(0,1,K,3'b010,3'b010,10'h000,10'h114,10'h000, 3'b010,10'h114,3'b010,0,1));
        tab2.push_back(mk(0,1,K,3'b000,3'b000,10'h000,10'h000,10'h000, 3'b000,10'h3BC,3'b000,0,0));
        tab2.push_back(mk(0,1,K,3'b001,3'b000,10'h041,10'h000,10'h000, 3'b001,10'h041,3'b001,0,1));
        tab2.push_back(mk(1,1,K,3'b001,3'b000,10'h042,10'h000,10'h000, 3'b001,10'h3BC,3'b000,0,0));
        tab2.push_back(mk(0,1,K,3'b011,3'b000,10'h050,10'h060,10'h000, 3'b001,10'h050,3'b001,0,1));
        tab2.push_back(mk(0,1,K,3'b011,3'b001,10'h051,10'h060,10'h000, 3'b001,10'h051,3'b001,0,1));
        tab2.push_back(mk(0,1,K,3'b000,3'b000,10'h000,10'h000,10'h000, 3'b000,10'h3BC,3'b000,0,0));

        rst = 1'b1; word_ce = 1'b0; kchar_comma = K;
        tx_valid = 3'b000; tx_last = 3'b000;
        tx_data0 = '0; tx_data1 = '0; tx_data2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset data_tra_out", 32'(data_tra_out), 32'h3BC);
        check("reset buffer_en", 32'({buffer_en2, buffer_en1, buffer_en0}), 32'h0);
        check("reset frame_abort", 32'(frame_abort), 32'h0);
        check("reset busy", 32'(busy), 32'h0);

        foreach (tab1[i]) apply(tab1[i]);

        // Underrun with word_ce on every 3rd clk: source 0 stalls for two ce slots mid-frame.
        begin
            logic [5:0] uv  = 6'b011001;
            logic [5:0] ul  = 6'b010000;
            logic [9:0] ud  [6] = '{10'h201, 10'h000, 10'h000, 10'h202, 10'h203, 10'h000};
            logic [9:0] ued [6] = '{10'h201, 10'h3BC, 10'h3BC, 10'h202, 10'h203, 10'h3BC};
            logic [2:0] uer [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
            logic [2:0] uen [6] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b001, 3'b000};
            logic [5:0] ub  = 6'b011111;
            logic [9:0] prev_data = 10'h3BC;
            logic [2:0] prev_en   = 3'b000;
            logic       prev_busy = 1'b0;
            for (int s = 0; s < 6; s++) begin
                for (int j = 0; j < 3; j++) begin
                    if (j == 2) begin
                        apply(mk(0,1,K,{2'b00,uv[s]},{2'b00,ul[s]},ud[s],10'h000,10'h000,
                                 uer[s],ued[s],uen[s],0,ub[s]));
                        prev_data = ued[s]; prev_en = uen[s]; prev_busy = ub[s];
                    end else begin
                        apply(mk(0,0,K,{2'b00,uv[s]},{2'b00,ul[s]},ud[s],10'h000,10'h000,
                                 3'b000,prev_data,prev_en,0,prev_busy));
                    end
                end
            end
        end

        foreach (tab2[i]) apply(tab2[i]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
